// File: rtl/minesweeper_pkg.sv
// Shared board geometry and button-event payload for the minesweeper blocks
// (cursor_ctrl, tile_state).
package minesweeper_pkg;

  localparam int unsigned BOARD_GRID  = 5;
  localparam int unsigned BOARD_TILES = BOARD_GRID * BOARD_GRID;
  localparam int unsigned COORD_W     = $clog2(BOARD_GRID);
  localparam int unsigned INDEX_W     = $clog2(BOARD_TILES);

  // One-cycle debounced press events, one bit per player button
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic flag;
    logic reveal;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, consecutive-sample debouncer and
// a registered single-cycle press (0->1) event.
module btn_debounce
  import minesweeper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Level flips after DEBOUNCE_CYCLES disagreeing samples; the press event
  // fires on the same edge that the level goes high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Board cursor: debounced buttons move the cursor and issue flag/reveal
// commands against the tile under it. Define CURSOR_WRAP_EN to wrap at edges.
module cursor_ctrl
  import minesweeper_pkg::*;
#(
  parameter int unsigned GRID_SIZE       = BOARD_GRID,
  parameter int unsigned TOTAL_TILES     = GRID_SIZE * GRID_SIZE,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_flag,
  input  logic                           btn_reveal,
  input  logic                           game_active,
  output logic [$clog2(GRID_SIZE)-1:0]   cursor_x,
  output logic [$clog2(GRID_SIZE)-1:0]   cursor_y,
  output logic [$clog2(TOTAL_TILES)-1:0] tile_index,
  output logic                           flag,
  output logic                           reveal
);

  localparam int unsigned XW = $clog2(GRID_SIZE);
  localparam int unsigned IW = $clog2(TOTAL_TILES);
  localparam logic [XW-1:0] MAX_C = XW'(GRID_SIZE - 1);

  // Coordinate produced by stepping below 0 / above the last tile
`ifdef CURSOR_WRAP_EN
  localparam logic [XW-1:0] PAST_LO = MAX_C;
  localparam logic [XW-1:0] PAST_HI = '0;
`else
  localparam logic [XW-1:0] PAST_LO = '0;
  localparam logic [XW-1:0] PAST_HI = MAX_C;
`endif

  btn_evt_t      ev;
  logic [XW-1:0] x_nxt;
  logic [XW-1:0] y_nxt;
  logic [IW-1:0] idx_c;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up
    (.clk(clk), .rst(rst), .btn(btn_up),     .rise(ev.up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down
    (.clk(clk), .rst(rst), .btn(btn_down),   .rise(ev.down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left
    (.clk(clk), .rst(rst), .btn(btn_left),   .rise(ev.left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right
    (.clk(clk), .rst(rst), .btn(btn_right),  .rise(ev.right));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_flag
    (.clk(clk), .rst(rst), .btn(btn_flag),   .rise(ev.flag));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reveal
    (.clk(clk), .rst(rst), .btn(btn_reveal), .rise(ev.reveal));

  // Next cursor position; opposing events on one axis cancel
  always_comb begin
    x_nxt = cursor_x;
    y_nxt = cursor_y;
    if (ev.left && !ev.right) begin
      x_nxt = (cursor_x == '0) ? PAST_LO : cursor_x - XW'(1);
    end else if (ev.right && !ev.left) begin
      x_nxt = (cursor_x == MAX_C) ? PAST_HI : cursor_x + XW'(1);
    end
    if (ev.up && !ev.down) begin
      y_nxt = (cursor_y == '0) ? PAST_LO : cursor_y - XW'(1);
    end else if (ev.down && !ev.up) begin
      y_nxt = (cursor_y == MAX_C) ? PAST_HI : cursor_y + XW'(1);
    end
  end

  // Index of the tile under the cursor before this cycle's move
  always_comb begin
    idx_c = IW'(cursor_y) * IW'(GRID_SIZE) + IW'(cursor_x);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_x   <= '0;
      cursor_y   <= '0;
      tile_index <= '0;
      flag       <= 1'b0;
      reveal     <= 1'b0;
    end else begin
      tile_index <= idx_c;
      flag       <= game_active & ev.flag;
      reveal     <= game_active & ev.reveal & ~ev.flag;
      if (game_active) begin
        cursor_x <= x_nxt;
        cursor_y <= y_nxt;
      end
    end
  end

endmodule
